// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared opcodes, FSM states and datapath mux encodings for the
//           multi-cycle RV32I control path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_TRAP     = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // fetch_upd / branch are qualifiers: the top gates them with mem_ready / zero
    typedef struct packed {
        logic       fetch_upd;
        logic       branch;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_state_decode.sv
// ============================================================================
// Module  : mc_state_decode
// Purpose : Purely combinational state -> Moore control output decode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_state_decode
    import riscv_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.fetch_upd  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = RES_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.branch     = 1'b1;
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = RES_ALUOUT;
            end
            S_TRAP: begin
                ctrl.illegal    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module  : multicycle_control
// Purpose : Main control FSM of the multi-cycle RV32I core. Optional perf
//           counters are built when MC_PERF_CNT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import riscv_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               illegal,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt,
`endif
    output logic [STATE_W-1:0] state_o
);

    state_e r_state;
    state_e w_next;
    ctrl_t  w_ctrl;

    if (STATE_W < 4 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control: STATE_W must be >= 4 and CNT_W >= 1");
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_EXECR;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_TRAP;
                endcase
            end
            // Only lw/sw reach here and the IR is frozen, so anything but lw is sw
            S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    mc_state_decode u_decode (
        .state (r_state),
        .ctrl  (w_ctrl)
    );

    // Write/access strobes are suppressed in the reset cycle so an abandoned
    // access never commits.
    assign pc_write   = ~reset & ((w_ctrl.fetch_upd & mem_ready) | (w_ctrl.branch & zero));
    assign ir_write   = ~reset & w_ctrl.fetch_upd & mem_ready;
    assign mem_read   = ~reset & w_ctrl.mem_read;
    assign mem_write  = ~reset & w_ctrl.mem_write;
    assign reg_write  = ~reset & w_ctrl.reg_write;
    assign adr_src    = w_ctrl.adr_src;
    assign result_src = w_ctrl.result_src;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_op     = w_ctrl.alu_op;
    assign illegal    = w_ctrl.illegal;
    assign state_o    = STATE_W'(r_state);

`ifdef MC_PERF_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ)
                   || ((r_state == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else if (r_state != S_TRAP) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_retire) r_instret_cnt <= r_instret_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

`default_nettype wire
